// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding an LSB-first serialiser.
// Each bit lasts BAUD_DIV clocks. Back-to-back frames are sent with no idle gap.
module uart_tx #(
  parameter int unsigned BAUD_DIV   = 432,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] TX_DATA,
  input  logic       TX_SEND,
  output logic       TX_FULL,
  output logic       TX_BUSY,
  output logic       TX_OVERRUN,
  output logic       TX_PIN
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC   = CntW'(FIFO_DEPTH);
  localparam logic [15:0]     BaudLast = 16'(BAUD_DIV - 1);
  localparam logic            StopLast = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [15:0]     baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic            stop_q, stop_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            ovr_q, ovr_d;
  logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic push, pop, empty, baud_done;

  // Full/busy come from registered state only; the write decision uses the pre-edge count.
  assign empty      = (cnt_q == '0);
  assign TX_FULL    = (cnt_q == DepthC);
  assign TX_BUSY    = !empty || (state_q != StIdle);
  assign TX_OVERRUN = ovr_q;
  assign TX_PIN     = tx_q;
  assign push       = TX_SEND && !TX_FULL;
  assign baud_done  = (baud_q == BaudLast);

  // Frame sequencer: decides the next line level, shift contents and FIFO pop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_q];
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        baud_d = baud_q + 16'd1;
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = StData;
        end
      end
      StData: begin
        baud_d = baud_q + 16'd1;
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            stop_d  = 1'b0;
            state_d = StStop;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      StStop: begin
        baud_d = baud_q + 16'd1;
        if (baud_done) begin
          baud_d = '0;
          if (stop_q != StopLast) begin
            stop_d = 1'b1;
          end else if (!empty) begin
            // Chain straight into the next start bit.
            pop     = 1'b1;
            shift_d = mem_q[rd_q];
            tx_d    = 1'b0;
            stop_d  = 1'b0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO pointer/count bookkeeping and overrun detection.
  always_comb begin
    wr_d  = push ? wr_q + PtrW'(1) : wr_q;
    rd_d  = pop ? rd_q + PtrW'(1) : rd_q;
    cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    ovr_d = TX_SEND && TX_FULL;
  end

  // FIFO storage; contents need no reset since the count qualifies them.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q] <= TX_DATA;
  end

  // State and control registers; reset forces the line high at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovr_q   <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovr_q   <= ovr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: scoreboarded loopback receiver on a 1-stop instance, plus a
// waveform comparison on a 2-stop instance.
module tb_uart_tx;

  localparam int unsigned Baud = 4;

  logic       clk, rst_n;
  logic [7:0] tx_data, tx_data2;
  logic       tx_send, tx_send2;
  logic       tx_full, tx_busy, tx_overrun, tx_pin;
  logic       full2, busy2, ovr2, pin2;

  uart_tx #(.BAUD_DIV(Baud), .FIFO_DEPTH(4), .STOP_BITS(1)) u_dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .TX_DATA   (tx_data),
    .TX_SEND   (tx_send),
    .TX_FULL   (tx_full),
    .TX_BUSY   (tx_busy),
    .TX_OVERRUN(tx_overrun),
    .TX_PIN    (tx_pin)
  );

  uart_tx #(.BAUD_DIV(Baud), .FIFO_DEPTH(2), .STOP_BITS(2)) u_dut2 (
    .CLK       (clk),
    .RST_N     (rst_n),
    .TX_DATA   (tx_data2),
    .TX_SEND   (tx_send2),
    .TX_FULL   (full2),
    .TX_BUSY   (busy2),
    .TX_OVERRUN(ovr2),
    .TX_PIN    (pin2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int frames = 0;
  int rst_events = 0;
  logic [7:0] sb[$];
  int starts[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) rst_events++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_idle(input int bound, output int n);
    n = 0;
    while (tx_busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic logic exp_bit(input int j, input logic [7:0] v);
    if (j < 4) return 1'b0;
    if (j < 36) return v[(j - 4) / 4];
    return 1'b1;
  endfunction

  // Loopback receiver: samples mid-bit, pops the scoreboard per completed frame.
  initial begin : rx_model
    logic [7:0] b;
    logic st, sp;
    int r0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_pin === 1'b0) begin
        r0 = rst_events;
        starts.push_back(cyc);
        repeat (Baud / 2) @(negedge clk);
        st = tx_pin;
        for (int i = 0; i < 8; i++) begin
          repeat (Baud) @(negedge clk);
          b[i] = tx_pin;
        end
        repeat (Baud) @(negedge clk);
        sp = tx_pin;
        if (r0 == rst_events) begin
          check("rx_start_bit", 32'(st), 32'd0);
          check("rx_stop_bit", 32'(sp), 32'd1);
          check("rx_frame_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) check("rx_data", 32'(b), 32'(sb.pop_front()));
          frames++;
        end
        repeat (Baud / 2 - 1) @(negedge clk);
      end
    end
  end

  initial begin : stim
    int n, f0, low, mm0, mm1;
    logic cap [88];
    logic [7:0] bytes2 [3];
    rst_n = 1'b0; tx_data = '0; tx_send = 1'b0; tx_data2 = '0; tx_send2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pin", 32'(tx_pin), 32'd1);
    check("rst_full", 32'(tx_full), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_ovr", 32'(tx_overrun), 32'd0);
    check("rst_pin2", 32'(pin2), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte: latency and frame duration.
    tx_data = 8'h55; tx_send = 1'b1; sb.push_back(8'h55);
    @(negedge clk);
    tx_send = 1'b0; tx_data = 8'hC3;
    check("t1_pin_still_high", 32'(tx_pin), 32'd1);
    check("t1_busy_rise", 32'(tx_busy), 32'd1);
    @(negedge clk);
    check("t1_pin_low", 32'(tx_pin), 32'd0);
    wait_idle(200, n);
    check("t1_busy_fall_cycles", 32'(n), 32'd40);
    repeat (5) @(negedge clk);
    check("t1_frames", 32'(frames), 32'd1);

    // Three consecutive writes: contiguous frames, in order.
    starts.delete();
    f0 = frames;
    bytes2 = '{8'h00, 8'hFF, 8'hA5};
    for (int i = 0; i < 3; i++) begin
      tx_data = bytes2[i]; tx_send = 1'b1; sb.push_back(bytes2[i]);
      @(negedge clk);
    end
    tx_send = 1'b0;
    wait_idle(300, n);
    check("t2_idle_in_time", 32'(n < 300), 32'd1);
    check("t2_frames", 32'(frames - f0), 32'd3);
    check("t2_starts", 32'(starts.size()), 32'd3);
    if (starts.size() >= 3) begin
      check("t2_gap01", 32'(starts[1] - starts[0]), 32'd40);
      check("t2_gap12", 32'(starts[2] - starts[1]), 32'd40);
    end
    repeat (3) @(negedge clk);

    // Six consecutive writes: five accepted, one overrun.
    f0 = frames;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t3_full_%0d", i), 32'(tx_full), 32'(i == 5));
      if (i > 0) check($sformatf("t3_no_ovr_%0d", i), 32'(tx_overrun), 32'd0);
      tx_data = 8'h10 + 8'(i); tx_send = 1'b1;
      if (i < 5) sb.push_back(8'h10 + 8'(i));
      @(negedge clk);
    end
    tx_send = 1'b0; tx_data = 8'hEE;
    check("t3_ovr_pulse", 32'(tx_overrun), 32'd1);
    @(negedge clk);
    check("t3_ovr_one_cycle", 32'(tx_overrun), 32'd0);
    wait_idle(400, n);
    check("t3_idle_in_time", 32'(n < 400), 32'd1);
    check("t3_frames", 32'(frames - f0), 32'd5);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);

    // Reset during data bit 3 with a second byte still queued.
    f0 = frames;
    tx_data = 8'h0F; tx_send = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tx_send = 1'b0;
    check("t4_pin_low", 32'(tx_pin), 32'd0);
    repeat (18) @(negedge clk);
    check("t4_bit3", 32'(tx_pin), 32'd1);
    check("t4_busy_pre", 32'(tx_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t4_async_pin", 32'(tx_pin), 32'd1);
    check("t4_async_busy", 32'(tx_busy), 32'd0);
    check("t4_async_full", 32'(tx_full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    low = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (tx_pin !== 1'b1) low++;
    end
    check("t4_no_low_after_rst", 32'(low), 32'd0);
    check("t4_no_frame", 32'(frames - f0), 32'd0);
    check("t4_busy_low", 32'(tx_busy), 32'd0);

    // Two stop bits: two contiguous 44-cycle frames of 0x81.
    tx_data2 = 8'h81; tx_send2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tx_send2 = 1'b0;
    for (int i = 0; i < 88; i++) begin
      cap[i] = pin2;
      @(negedge clk);
    end
    mm0 = 0; mm1 = 0;
    for (int j = 0; j < 44; j++) begin
      if (cap[j] !== exp_bit(j, 8'h81)) mm0++;
      if (cap[44 + j] !== exp_bit(j, 8'h81)) mm1++;
    end
    check("t5_frame0_mismatches", 32'(mm0), 32'd0);
    check("t5_frame1_mismatches", 32'(mm1), 32'd0);
    check("t5_busy_end", 32'(busy2), 32'd0);
    check("t5_pin_end", 32'(pin2), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
